// File: rtl/shared_mem_pkg.sv
// Shared constants, FSM state type and round-robin pick helper for shared_mem_arbiter.
package shared_mem_pkg;

    localparam int unsigned N_PORTS = 4;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned ADDR_W  = 4;
    localparam int unsigned PORT_W  = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    typedef struct packed {
        logic              valid;
        logic [PORT_W-1:0] idx;
    } pick_t;

    // First requesting port strictly after ptr, wrapping modulo N_PORTS;
    // ptr itself is considered last.
    function automatic pick_t rr_pick(input logic [N_PORTS-1:0] req,
                                      input logic [PORT_W-1:0]  ptr);
        pick_t             p;
        logic [PORT_W-1:0] cand;
        p = '0;
        for (int unsigned off = 1; off <= N_PORTS; off++) begin
            cand = PORT_W'((32'(ptr) + off) % N_PORTS);
            if (!p.valid && req[cand]) begin
                p.valid = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_arbiter.sv
// Combinational round-robin grant selection; the rotating pointer is held by the parent.
module rr_arbiter
    import shared_mem_pkg::*;
(
    input  logic [N_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]  ptr_i,
    output logic               valid_o,
    output logic [PORT_W-1:0]  gnt_o
);

    pick_t pick;

    assign pick    = rr_pick(req_i, ptr_i);
    assign valid_o = pick.valid;
    assign gnt_o   = pick.idx;

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin serialised access to a fixed-latency shared memory array.
module shared_mem_arbiter
    import shared_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        rd,
    input  logic [N_PORTS-1:0]        wr,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    output logic [DATA_W-1:0]         rdata,
    output logic [N_PORTS-1:0]        p_rdy,
    output logic                      busy
);

    localparam int unsigned CNT_W = $clog2(LATENCY + 1);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q;
    logic [PORT_W-1:0]   rr_ptr_q;
    logic [PORT_W-1:0]   gnt_q;
    logic                wr_q;
    logic [ADDR_W-1:0]   a_q;
    logic [DATA_W-1:0]   wd_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [N_PORTS-1:0]  p_rdy_q;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    logic [N_PORTS-1:0]  req;
    logic                pick_valid;
    logic [PORT_W-1:0]   pick_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;
    logic                grant_en;
    logic                complete;

    // A port with both rd and wr set still counts as one request; wr wins when latched.
    assign req = rd | wr;

    rr_arbiter u_rr (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (pick_valid),
        .gnt_o   (pick_idx)
    );

    // Mux out the granted port's address and write data.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            if (PORT_W'(i) == pick_idx) begin
                sel_addr  = addr[i*ADDR_W +: ADDR_W];
                sel_wdata = wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; DONE always returns to IDLE so no re-grant happens in the strobe cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (pick_valid) state_d = BUSY;
            BUSY: if (cnt_q == '0) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath strobes.
    always_comb begin
        busy     = (state_q != IDLE);
        grant_en = (state_q == IDLE) && pick_valid;
        complete = (state_q == BUSY) && (cnt_q == '0);
    end

    // Grant latch, latency counter, array access and completion strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rr_ptr_q <= PORT_W'(N_PORTS - 1);
            gnt_q    <= '0;
            wr_q     <= 1'b0;
            a_q      <= '0;
            wd_q     <= '0;
            rdata_q  <= '0;
            p_rdy_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[ADDR_W'(i)] <= '0;
            end
        end else begin
            p_rdy_q <= '0;
            if (grant_en) begin
                gnt_q    <= pick_idx;
                wr_q     <= wr[pick_idx];
                a_q      <= sel_addr;
                wd_q     <= sel_wdata;
                rr_ptr_q <= pick_idx;
                cnt_q    <= CNT_W'(LATENCY - 1);
            end
            if ((state_q == BUSY) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (complete) begin
                if (wr_q) begin
                    mem_q[a_q] <= wd_q;
                    rdata_q    <= wd_q;
                end else begin
                    rdata_q    <= mem_q[a_q];
                end
                p_rdy_q[gnt_q] <= 1'b1;
            end
        end
    end

    assign rdata = rdata_q;
    assign p_rdy = p_rdy_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Scoreboard bench for shared_mem_arbiter: expected completions queued at drive time, popped on p_rdy.
module tb_shared_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  rd;
    logic [3:0]  wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [7:0]  rdata;
    logic [3:0]  p_rdy;
    logic        busy;

    typedef struct {
        logic [3:0] rdy;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t ent;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    shared_mem_arbiter #(.LATENCY(2)) dut (
        .clk   (clk),
        .rst   (rst),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .p_rdy (p_rdy),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] r, input logic [7:0] d);
        exp_t e;
        e.rdy  = r;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic set_req(input int p, input logic r, input logic w,
                           input logic [3:0] a, input logic [7:0] d);
        rd[p]           = r;
        wr[p]           = w;
        addr[p*4 +: 4]  = a;
        wdata[p*8 +: 8] = d;
    endtask

    task automatic clr(input int p);
        rd[p] = 1'b0;
        wr[p] = 1'b0;
    endtask

    // Bounded wait for the next p_rdy pulse, sampled on the falling edge.
    task automatic wait_done(input string tag, output int c);
        int got;
        got = 0;
        c   = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (p_rdy !== 4'b0000) begin
                got = 1;
                c   = cyc;
                break;
            end
        end
        chk(tag, got, 1);
    endtask

    // Single transaction from IDLE; called and returns just after a rising edge.
    task automatic run_one(input string tag, input int p, input logic r, input logic w,
                           input logic [3:0] a, input logic [7:0] d, input logic [7:0] exp_d);
        int t0;
        int c;
        t0 = cyc;
        push(4'(1 << p), exp_d);
        set_req(p, r, w, a, d);
        wait_done(tag, c);
        chk({tag, "_lat"}, c - t0, 3);
        @(posedge clk); #1;
        clr(p);
    endtask

    // Scoreboard consumer: every completion strobe must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && p_rdy !== 4'b0000) begin
            if (sb.size() == 0) begin
                chk("spurious_rdy", p_rdy, 0);
            end else begin
                ent = sb.pop_front();
                chk("p_rdy", p_rdy, ent.rdy);
                chk("rdata", rdata, ent.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c[6];
        int c1, c2, bc, seen;

        rst = 1'b1; rd = '0; wr = '0; addr = '0; wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_p_rdy", p_rdy, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Fairness: all ports writing continuously; order 0,1,2,3,0,1 from reset pointer.
        for (int i = 0; i < 4; i++) set_req(i, 1'b0, 1'b1, 4'(12 + i), 8'(8'h40 + i));
        push(4'b0001, 8'h40); push(4'b0010, 8'h41); push(4'b0100, 8'h42);
        push(4'b1000, 8'h43); push(4'b0001, 8'h40); push(4'b0010, 8'h41);
        for (int k = 0; k < 6; k++) wait_done("fair_done", c[k]);
        @(posedge clk); #1;
        rd = '0; wr = '0;
        for (int k = 1; k < 6; k++) chk("fair_gap", c[k] - c[k-1], 4);

        // Write then read from another port.
        run_one("wr3", 0, 1'b0, 1'b1, 4'd3, 8'hA5, 8'hA5);
        run_one("rd3", 2, 1'b1, 1'b0, 4'd3, 8'h00, 8'hA5);

        // rd+wr together is a write.
        run_one("rdwr0", 2, 1'b1, 1'b1, 4'd0, 8'h3C, 8'h3C);
        run_one("rd0", 3, 1'b1, 1'b0, 4'd0, 8'h00, 8'h3C);

        // Race on addr 5: pointer at 3, so port 1 is served before port 3.
        push(4'b0010, 8'h11); push(4'b1000, 8'h22);
        set_req(1, 1'b0, 1'b1, 4'd5, 8'h11);
        set_req(3, 1'b0, 1'b1, 4'd5, 8'h22);
        wait_done("race_a", c1);
        @(posedge clk); #1; clr(1);
        wait_done("race_b", c2);
        @(posedge clk); #1; clr(3);
        chk("race_gap", c2 - c1, 4);
        run_one("rd5", 0, 1'b1, 1'b0, 4'd5, 8'h00, 8'h22);

        // Never-written address reads zero; busy spans BUSY+DONE.
        push(4'b0010, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd9, 8'h00);
        seen = 0; bc = 0;
        for (int k = 0; k < 12 && seen == 0; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (p_rdy !== 4'b0000) seen = 1;
        end
        chk("rd9_seen", seen, 1);
        @(posedge clk); #1; clr(1);
        @(negedge clk);
        if (busy) bc++;
        chk("busy_cycles", bc, 3);
        @(posedge clk); #1;

        // Reset while BUSY aborts the write to addr 7.
        set_req(0, 1'b0, 1'b1, 4'd7, 8'hFF);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_p_rdy", p_rdy, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdata", rdata, 0);
        clr(0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("post_rst_idle", p_rdy, 0);
        @(posedge clk); #1;
        push(4'b0001, 8'h00); push(4'b0100, 8'h00);
        set_req(0, 1'b1, 1'b0, 4'd7, 8'h00);
        set_req(2, 1'b1, 1'b0, 4'd3, 8'h00);
        wait_done("post_rst_a", c1);
        @(posedge clk); #1; clr(0);
        wait_done("post_rst_b", c2);
        @(posedge clk); #1; clr(2);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
- Shared backing store for the four-core coherency examples; sits directly downstream of the per-core caches.
- Accepts the caches' memory-side rd/wr/wdata requests, serialises them with a round-robin arbiter and models a fixed-latency memory array.
- Returns read data and a per-port p_rdy completion strobe, the same strobes the bus monitor watches.
- Non-coherent by design: no snooping, no invalidation, just ordered serialisation of accesses.

Parameters:
- N_PORTS, 4, number of requesting cores; the RTL is verified only at 4.
- DATA_W, 8, data width.
- ADDR_W, 4, word address width; the array has 2**ADDR_W words.
- LATENCY, 2, number of BUSY cycles per access; legal range 1..15.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous and active-high.
- rd  in  N_PORTS  per-port read request (level).
- wr  in  N_PORTS  per-port write request (level).
- addr  in  N_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
- wdata  in  N_PORTS*DATA_W  per-port write data; port i occupies bits [i*DATA_W +: DATA_W].
- rdata  out  DATA_W  data returned by the last completed access; shared by all ports.
- p_rdy  out  N_PORTS  one-cycle completion strobe, at most one bit set.
- busy  out  1  high in the BUSY and DONE states.

Behaviour:
- Reset values (asynchronous, on rst high):
  - FSM in IDLE; LATENCY counter = 0.
  - rr_ptr = N_PORTS-1, so port 0 has first priority.
  - rdata = 0, p_rdy = 0, busy = 0; all array words = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - req[i] = rd[i] | wr[i].
  - If any req bit is set, grant the first requesting port searching from rr_ptr+1 upward, modulo N_PORTS.
  - At the edge: latch gnt, op, addr and wdata of the granted port; rr_ptr <= gnt; cnt <= LATENCY-1; go to BUSY.
  - If no request, stay in IDLE.
- BUSY:
  - Latched values are used; inputs are ignored.
  - Decrement cnt each cycle.
  - At the edge where cnt == 0:
    - Write: mem[a] <= wd; rdata <= wd.
    - Read: rdata <= mem[a].
    - p_rdy[gnt] <= 1; go to DONE.
- DONE: p_rdy is high for exactly this cycle; at the next edge p_rdy <= 0 and go to IDLE.
- Latency: a request first seen in IDLE cycle T completes with p_rdy high in cycle T+LATENCY+1.
- Minimum spacing between grants is LATENCY+2 cycles.
- Handshake:
  - A requester holds rd/wr, addr and wdata until it sees p_rdy, and deasserts at the edge that ends the p_rdy cycle.
  - The arbiter never re-grants in the DONE cycle, so there is no double service.
- rd and wr both high on one port: the access is a write, and rdata returns the written value.
- A request dropped early (while BUSY) is a protocol violation. The access still completes: any write is committed and p_rdy still pulses.
- Requests from non-granted ports may assert or drop at any time without effect until the next IDLE.
- rdata holds its value between completions.
- A write followed by a read from another port to the same address returns the new value; accesses are strictly serialised.
- Reset mid-operation (BUSY or DONE): the access is aborted and no write is committed. p_rdy drops asynchronously and all reset values apply.
- cnt is $clog2(LATENCY+1) bits wide and never wraps; it is reloaded on every grant.

Decomposition:
- Package shared_mem_pkg holds:
  - constants N_PORTS, DATA_W, ADDR_W;
  - the state enum {IDLE, BUSY, DONE};
  - a function rr_pick(req, ptr) returning the grant index and a valid bit.
- One sub-module, rr_arbiter: combinational round-robin pick from req and rr_ptr; rr_ptr itself stays in the parent.
- The array, FSM and counter live in shared_mem_arbiter.

Test Plan:
- Reset then single write: port 0 wr, addr=3, wdata=8'hA5 -> p_rdy=4'b0001 exactly 3 cycles after the first IDLE sample (LATENCY=2), rdata=8'hA5. Then port 2 rd, addr=3 -> p_rdy=4'b0100, rdata=8'hA5.
- Fairness: all four ports request continuously, re-asserting after each p_rdy -> grant order 0,1,2,3,0,1; p_rdy pulses spaced 4 cycles apart.
- Non-coherent race: port 1 writes addr 5 = 8'h11 while port 3 writes addr 5 = 8'h22, both raised in the same cycle -> port 1 is served first; a final read of addr 5 returns 8'h22.
- Simultaneous rd+wr on port 2, addr=0, wdata=8'h3C -> treated as a write; rdata=8'h3C; a later read of addr 0 returns 8'h3C.
- Reset mid-BUSY: port 0 writes addr 7 = 8'hFF and rst is pulsed while in BUSY -> p_rdy stays 0; after reset, a read of addr 7 returns 8'h00 and the next grant goes to port 0.
- Unrequested read: read of addr 9 with no prior write -> rdata=8'h00; busy high for LATENCY+1 cycles.
